ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage that sits directly downstream of the 64-bit ALU built from the bit-slice array.
- Registers the ALU result, carry-out and overflow along with the instruction's control bits.
- Derives the N and Z flags and maintains the architectural NZCV flag register.
- Resolves CBZ and B.LT branches and presents them to the memory stage, with stall and flush support.

Parameters:
- WIDTH, 64, datapath width of the result and store data.
- REG_BITS, 5, width of the destination register index.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  the EX stage holds a real instruction.
- ex_alu_cntrl  in  3  ALU operation code: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
- ex_result  in  WIDTH  ALU result.
- ex_carry_out  in  1  ALU carry-out of the MSB slice.
- ex_overflow  in  1  ALU signed overflow.
- ex_set_flags  in  1  the instruction is flag-setting (ADDS/SUBS/ANDS).
- ex_br_type  in  2  00 none, 01 CBZ, 10 B.LT, 11 reserved (treated as none).
- ex_rd  in  REG_BITS  destination register.
- ex_reg_write  in  1  register-write enable.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_store_data  in  WIDTH  store data.
- stall  in  1  hold the MEM-side registers.
- flush  in  1  squash the instruction entering MEM.
- mem_valid  out  1  MEM stage holds a real instruction.
- mem_result  out  WIDTH  registered result.
- mem_store_data  out  WIDTH  registered store data.
- mem_rd  out  REG_BITS  registered destination register.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered controls, already gated by valid.
- mem_br_taken  out  1  registered branch decision.
- flag_n, flag_z, flag_c, flag_v  out  1 each  architectural flag register.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0 immediately, including the flags and mem_valid.
  - Reset asserted mid-operation discards the in-flight instruction; no partial update survives.
- Capture:
  - Condition is "advance = !stall".
  - On a rising edge with advance: mem_valid <= ex_valid & !flush.
  - All data and control fields are captured from the EX inputs.
  - mem_reg_write, mem_mem_read and mem_mem_write are each ANDed with (ex_valid & !flush).
- Latency: 1 cycle from EX inputs to mem_* outputs.
- Stall:
  - All mem_* registers and the flags hold their values.
  - stall has priority over flush: with both high, nothing changes and the flush is not remembered.
- Flush with !stall:
  - mem_valid, the controls and mem_br_taken go to 0.
  - Data fields are don't-care (captured normally).
  - Flags do not update.
- Flag update: occurs only when advance & ex_valid & !flush & ex_set_flags.
  - N <= ex_result[WIDTH-1].
  - Z <= (ex_result == 0).
  - C <= ex_carry_out and V <= ex_overflow when ex_alu_cntrl is 010 or 011; otherwise C and V <= 0.
  - In all other cases the flags hold.
- Branch decision:
  - Computed combinationally in EX, then registered into mem_br_taken on advance.
  - CBZ: taken when ex_result == 0. The ALU is in pass-B mode and ex_result carries the tested register.
  - B.LT: taken when flag_n != flag_v, using the flag register value before this edge (the flags of the most recent older flag-setting instruction).
  - An instruction that both sets flags and is B.LT is illegal; there is no defined requirement for it.
  - mem_br_taken is 0 whenever the captured instruction is invalid or flushed.
- Width rules:
  - Z compares all WIDTH bits.
  - No sign extension or truncation; every field is a straight register.
- Simultaneous events: stall + reset → reset wins; flush + set_flags → no flag update.

Test Plan:
- Reset: assert reset asynchronously between edges → all outputs 0 before the next clk edge; release → still 0 until the first valid capture.
- SUBS: ex_alu_cntrl=011, ex_result=64'h0, carry_out=1, overflow=0, set_flags=1 → after 1 edge NZCV=0110, mem_result=0, mem_valid=1.
- ANDS: ex_alu_cntrl=100, ex_result=64'h8000_0000_0000_0000, carry_out=1, overflow=1, set_flags=1 → NZCV=1000 (C and V forced to 0).
- B.LT:
  - Stimulus: ADDS with result 64'h8000_0000_0000_0001, overflow=0, followed by B.LT.
  - Required: N=1, V=0, so mem_br_taken=1 one cycle after the B.LT is presented.
  - Repeat with overflow=1 → mem_br_taken=0.
- CBZ: ex_br_type=01, ex_result=0 → mem_br_taken=1; ex_result=5 → mem_br_taken=0.
- Stall/flush:
  - Hold stall for 3 cycles with changing inputs → mem_* and the flags are frozen.
  - Flush with set_flags=1, reg_write=1 → mem_valid=0, mem_reg_write=0, flags unchanged.
  - stall and flush together → state frozen; the next cycle with both low captures normally.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX-to-MEM boundary bundle: EX-side instruction fields and pipeline controls
// in, MEM-side registered instruction and architectural flags out.
interface ex_mem_if #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
);
  logic                ex_valid;
  logic [2:0]          ex_alu_cntrl;
  logic [WIDTH-1:0]    ex_result;
  logic                ex_carry_out;
  logic                ex_overflow;
  logic                ex_set_flags;
  logic [1:0]          ex_br_type;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic [WIDTH-1:0]    ex_store_data;
  logic                stall;
  logic                flush;

  logic                mem_valid;
  logic [WIDTH-1:0]    mem_result;
  logic [WIDTH-1:0]    mem_store_data;
  logic [REG_BITS-1:0] mem_rd;
  logic                mem_reg_write;
  logic                mem_mem_read;
  logic                mem_mem_write;
  logic                mem_br_taken;
  logic                flag_n;
  logic                flag_z;
  logic                flag_c;
  logic                flag_v;

  // Pipeline handshake: an EX instruction transfers into MEM on any rising edge
  // where stall is low; ex_valid marks it real, flush squashes it on transfer.
  // With stall high nothing moves and a coincident flush is dropped.
  modport master (
    output ex_valid, ex_alu_cntrl, ex_result, ex_carry_out, ex_overflow,
           ex_set_flags, ex_br_type, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, stall, flush,
    input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_br_taken,
           flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  ex_valid, ex_alu_cntrl, ex_result, ex_carry_out, ex_overflow,
           ex_set_flags, ex_br_type, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, stall, flush,
    output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_br_taken,
           flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the ALU result and controls, keeps the
// NZCV flag register and resolves CBZ / B.LT for the memory stage.
module ex_mem_stage #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
) (
  input logic   clk,
  input logic   reset,
  ex_mem_if.slave bus
);
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [1:0] BR_CBZ  = 2'b01;
  localparam logic [1:0] BR_BLT  = 2'b10;

  logic                advance;
  logic                live;
  logic                result_zero;
  logic                arith_op;
  logic                br_take_ex;
  logic                flag_we;

  logic                mem_valid_q;
  logic [WIDTH-1:0]    mem_result_q;
  logic [WIDTH-1:0]    mem_store_data_q;
  logic [REG_BITS-1:0] mem_rd_q;
  logic                mem_reg_write_q;
  logic                mem_mem_read_q;
  logic                mem_mem_write_q;
  logic                mem_br_taken_q;
  logic                n_q, z_q, c_q, v_q;

  assign advance     = !bus.stall;
  assign live        = bus.ex_valid & !bus.flush;
  assign result_zero = (bus.ex_result == '0);
  assign arith_op    = (bus.ex_alu_cntrl == ALU_ADD) || (bus.ex_alu_cntrl == ALU_SUB);
  assign flag_we     = advance & live & bus.ex_set_flags;

  // B.LT reads the flag register as it stands before this edge, i.e. the flags
  // of the most recent older flag-setting instruction.
  always_comb begin
    br_take_ex = 1'b0;
    case (bus.ex_br_type)
      BR_CBZ:  br_take_ex = result_zero;
      BR_BLT:  br_take_ex = n_q ^ v_q;
      default: br_take_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_q      <= 1'b0;
      mem_result_q     <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_br_taken_q   <= 1'b0;
    end else if (advance) begin
      mem_valid_q      <= live;
      mem_result_q     <= bus.ex_result;
      mem_store_data_q <= bus.ex_store_data;
      mem_rd_q         <= bus.ex_rd;
      mem_reg_write_q  <= bus.ex_reg_write & live;
      mem_mem_read_q   <= bus.ex_mem_read & live;
      mem_mem_write_q  <= bus.ex_mem_write & live;
      mem_br_taken_q   <= br_take_ex & live;
    end
  end

  // Logical ops clear C and V rather than leaving stale arithmetic flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (flag_we) begin
      n_q <= bus.ex_result[WIDTH-1];
      z_q <= result_zero;
      c_q <= arith_op & bus.ex_carry_out;
      v_q <= arith_op & bus.ex_overflow;
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_result     = mem_result_q;
  assign bus.mem_store_data = mem_store_data_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_mem_read   = mem_mem_read_q;
  assign bus.mem_mem_write  = mem_mem_write_q;
  assign bus.mem_br_taken   = mem_br_taken_q;
  assign bus.flag_n         = n_q;
  assign bus.flag_z         = z_q;
  assign bus.flag_c         = c_q;
  assign bus.flag_v         = v_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table through a scoreboard queue, plus
// hand sequences for stall/flush freezing and asynchronous reset.
module tb_ex_mem_stage;
  localparam int W = 64;
  localparam int R = 5;

  typedef struct packed {
    logic         valid;
    logic [2:0]   alu;
    logic [W-1:0] result;
    logic         co;
    logic         ov;
    logic         sf;
    logic [1:0]   br;
    logic [R-1:0] rd;
    logic         rw;
    logic         mr;
    logic         mw;
    logic [W-1:0] sd;
    logic         stall;
    logic         flush;
  } in_t;

  typedef struct packed {
    logic         chk_data;
    logic         v;
    logic [W-1:0] result;
    logic [W-1:0] sd;
    logic [R-1:0] rd;
    logic         rw;
    logic         mr;
    logic         mw;
    logic         br;
    logic [3:0]   nzcv;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t tbl[14];
  exp_t last_exp;

  ex_mem_if #(.WIDTH(W), .REG_BITS(R)) bus ();

  ex_mem_stage #(.WIDTH(W), .REG_BITS(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    bus.ex_valid      = i.valid;
    bus.ex_alu_cntrl  = i.alu;
    bus.ex_result     = i.result;
    bus.ex_carry_out  = i.co;
    bus.ex_overflow   = i.ov;
    bus.ex_set_flags  = i.sf;
    bus.ex_br_type    = i.br;
    bus.ex_rd         = i.rd;
    bus.ex_reg_write  = i.rw;
    bus.ex_mem_read   = i.mr;
    bus.ex_mem_write  = i.mw;
    bus.ex_store_data = i.sd;
    bus.stall         = i.stall;
    bus.flush         = i.flush;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s scoreboard: act=empty exp=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " mem_valid"}, W'(bus.mem_valid), W'(e.v));
      chk({tag, " mem_reg_write"}, W'(bus.mem_reg_write), W'(e.rw));
      chk({tag, " mem_mem_read"}, W'(bus.mem_mem_read), W'(e.mr));
      chk({tag, " mem_mem_write"}, W'(bus.mem_mem_write), W'(e.mw));
      chk({tag, " mem_br_taken"}, W'(bus.mem_br_taken), W'(e.br));
      chk({tag, " nzcv"}, W'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), W'(e.nzcv));
      if (e.chk_data) begin
        chk({tag, " mem_result"}, bus.mem_result, e.result);
        chk({tag, " mem_store_data"}, bus.mem_store_data, e.sd);
        chk({tag, " mem_rd"}, W'(bus.mem_rd), W'(e.rd));
      end
    end
  endtask

  // Drive between edges, score one cycle later just after the capturing edge.
  task automatic step(input string tag, input in_t i, input exp_t e);
    @(negedge clk);
    drive(i);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_valid"}, W'(bus.mem_valid), '0);
    chk({tag, " mem_result"}, bus.mem_result, '0);
    chk({tag, " mem_store_data"}, bus.mem_store_data, '0);
    chk({tag, " mem_rd"}, W'(bus.mem_rd), '0);
    chk({tag, " controls"}, W'({bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write}), '0);
    chk({tag, " mem_br_taken"}, W'(bus.mem_br_taken), '0);
    chk({tag, " nzcv"}, W'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), '0);
  endtask

  initial begin
    in_t  idle;
    in_t  rin;
    exp_t zero_exp;

    idle = '0;
    zero_exp = '0;
    zero_exp.chk_data = 1'b1;

    // in: valid alu result co ov sf br rd rw mr mw sd stall flush
    // ex: chk v result sd rd rw mr mw br nzcv
    tbl[0]  = '{'{1'b1, 3'b011, 64'h0, 1'b1, 1'b0, 1'b1, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0, 64'h11, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h0, 64'h11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110}};
    tbl[1]  = '{'{1'b1, 3'b100, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 64'h22, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h22, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000}};
    tbl[2]  = '{'{1'b1, 3'b010, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b1, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 64'h33, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h8000_0000_0000_0001, 64'h33, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000}};
    tbl[3]  = '{'{1'b1, 3'b000, 64'h7, 1'b0, 1'b0, 1'b0, 2'b10, 5'd6, 1'b0, 1'b0, 1'b0, 64'h44, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h7, 64'h44, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000}};
    tbl[4]  = '{'{1'b1, 3'b010, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b1, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 64'h55, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h8000_0000_0000_0001, 64'h55, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011}};
    tbl[5]  = '{'{1'b1, 3'b000, 64'h7, 1'b0, 1'b0, 1'b0, 2'b10, 5'd6, 1'b0, 1'b0, 1'b0, 64'h44, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h7, 64'h44, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011}};
    tbl[6]  = '{'{1'b1, 3'b000, 64'h0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd8, 1'b0, 1'b0, 1'b0, 64'h66, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h0, 64'h66, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011}};
    tbl[7]  = '{'{1'b1, 3'b000, 64'h5, 1'b0, 1'b0, 1'b0, 2'b01, 5'd8, 1'b0, 1'b0, 1'b0, 64'h66, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h5, 64'h66, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011}};
    tbl[8]  = '{'{1'b1, 3'b010, 64'h100, 1'b0, 1'b0, 1'b0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0, 64'h77, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h100, 64'h77, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011}};
    tbl[9]  = '{'{1'b1, 3'b010, 64'h200, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h200, 64'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011}};
    tbl[10] = '{'{1'b0, 3'b011, 64'h0, 1'b1, 1'b1, 1'b1, 2'b01, 5'd9, 1'b1, 1'b1, 1'b1, 64'h88, 1'b0, 1'b0},
                '{1'b1, 1'b0, 64'h0, 64'h88, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011}};
    tbl[11] = '{'{1'b1, 3'b011, 64'h0, 1'b1, 1'b0, 1'b1, 2'b01, 5'd10, 1'b1, 1'b1, 1'b1, 64'h99, 1'b0, 1'b1},
                '{1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011}};
    tbl[12] = '{'{1'b1, 3'b000, 64'h0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd11, 1'b1, 1'b0, 1'b0, 64'hAA, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h0, 64'hAA, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011}};
    tbl[13] = '{'{1'b1, 3'b101, 64'h0, 1'b1, 1'b1, 1'b1, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0, 64'hBB, 1'b0, 1'b0},
                '{1'b1, 1'b1, 64'h0, 64'hBB, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100}};

    reset = 1'b1;
    drive(idle);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 14; k++) begin
      step($sformatf("vec%0d", k), tbl[k].in, tbl[k].ex);
    end

    // Stall for three cycles with changing flag-setting inputs: all frozen.
    last_exp = tbl[13].ex;
    for (int k = 0; k < 3; k++) begin
      rin = '0;
      rin.valid  = 1'b1;
      rin.alu    = 3'b011;
      rin.result = {$urandom(), $urandom()};
      rin.co     = 1'(($urandom_range(0, 1)));
      rin.ov     = 1'(($urandom_range(0, 1)));
      rin.sf     = 1'b1;
      rin.br     = 2'b01;
      rin.rd     = 5'($urandom_range(0, 31));
      rin.rw     = 1'b1;
      rin.mw     = 1'b1;
      rin.sd     = {$urandom(), $urandom()};
      rin.stall  = 1'b1;
      step($sformatf("stall%0d", k), rin, last_exp);
    end

    rin.flush = 1'b1;
    step("stall_flush", rin, last_exp);

    rin = '0;
    rin.valid  = 1'b1;
    rin.alu    = 3'b010;
    rin.result = 64'h1;
    rin.co     = 1'b1;
    rin.sf     = 1'b1;
    rin.rd     = 5'd9;
    rin.rw     = 1'b1;
    rin.sd     = 64'h1234;
    step("after_stall_flush", rin,
         '{1'b1, 1'b1, 64'h1, 64'h1234, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010});

    // Asynchronous reset between edges, with a live instruction in EX.
    @(negedge clk);
    drive(tbl[0].in);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    drive(idle);
    reset = 1'b0;
    #1;
    check_all_zero("reset_release");
    step("idle_after_reset", idle, zero_exp);
    step("first_capture", tbl[2].in, tbl[2].ex);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
